// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC ownership, icache read port, next-PC select
// Optional feature macro: FETCH_PERFCNT_EN (retired-instruction and icache-wait counters).
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] npc,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    input  logic        stall,
    output logic        halted,
    output logic [31:0] icount,
    output logic [31:0] wait_cycles
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_ISSUE  = 2'b01,
        S_HALTED = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] w_next_pc;
    logic [31:0] w_branch_off;
    logic [31:0] w_jr_target;
    logic        w_pc_load;
    logic        w_instr_load;
    logic        w_retire;

    assign npc          = r_pc + 32'd4;
    assign iaddr        = r_pc;
    assign instr        = r_instr;
    assign w_branch_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    // Register jumps ignore the low two bits so the PC stays word aligned.
    assign w_jr_target  = jr_addr & 32'hFFFF_FFFC;

    // State register; reset drops any icache response still in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state outputs; stall outranks halt, halt outranks pc_src.
    always_comb begin
        w_next_state = r_state;
        iREN         = 1'b0;
        instr_valid  = 1'b0;
        halted       = 1'b0;
        w_pc_load    = 1'b0;
        w_instr_load = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    w_instr_load = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    w_retire = 1'b1;
                    if (halt) begin
                        w_next_state = S_HALTED;
                    end else begin
                        w_pc_load    = 1'b1;
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Next-PC mux; all arithmetic wraps modulo 2^32.
    always_comb begin
        w_next_pc = npc;
        case (pc_src)
            2'b00: w_next_pc = npc;
            2'b01: w_next_pc = branch_taken ? (npc + w_branch_off) : npc;
            2'b10: w_next_pc = {npc[31:28], r_instr[25:0], 2'b00};
            2'b11: w_next_pc = w_jr_target;
            default: w_next_pc = npc;
        endcase
    end

    // PC advances only when leaving ISSUE toward FETCH, keeping iaddr stable per request.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pc <= PC_INIT;
        end else if (w_pc_load) begin
            r_pc <= w_next_pc;
        end
    end

    // Instruction latch captures the icache word on the hit cycle and holds it through ISSUE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instr <= 32'h0000_0000;
        end else if (w_instr_load) begin
            r_instr <= iload;
        end
    end

`ifdef FETCH_PERFCNT_EN
    logic [31:0] r_icount;
    logic [31:0] r_wait_cycles;

    // Performance counters: retirements and FETCH cycles spent waiting on the icache.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_icount      <= 32'h0000_0000;
            r_wait_cycles <= 32'h0000_0000;
        end else begin
            if (w_retire) begin
                r_icount <= r_icount + 32'd1;
            end
            if (r_state == S_FETCH && !ihit) begin
                r_wait_cycles <= r_wait_cycles + 32'd1;
            end
        end
    end

    assign icount      = r_icount;
    assign wait_cycles = r_wait_cycles;
`else
    assign icount      = 32'h0000_0000;
    assign wait_cycles = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] npc;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] jr_addr;
    logic        halt;
    logic        stall;
    logic        halted;
    logic [31:0] icount;
    logic [31:0] wait_cycles;

    int checks = 0;
    int errors = 0;

`ifdef FETCH_PERFCNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN),
        .iaddr(iaddr), .instr(instr), .instr_valid(instr_valid), .npc(npc),
        .pc_src(pc_src), .branch_taken(branch_taken), .jr_addr(jr_addr),
        .halt(halt), .stall(stall), .halted(halted), .icount(icount),
        .wait_cycles(wait_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the following falling edge for sampling/driving.
    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // From FETCH: hit with the given word, then check it is presented in ISSUE.
    task automatic fetch(input logic [31:0] word);
        chk("fetch_iren", {31'd0, iREN}, 32'd1);
        ihit  = 1'b1;
        iload = word;
        tick();
        ihit  = 1'b0;
        iload = 32'hDEAD_BEEF;
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        chk("issue_instr", instr, word);
    endtask

    // From ISSUE: apply the next-PC decision and check the new request address.
    task automatic retire(input logic [1:0] src, input logic taken,
                          input logic [31:0] jr, input logic [31:0] exp_addr);
        pc_src       = src;
        branch_taken = taken;
        jr_addr      = jr;
        tick();
        pc_src       = 2'b00;
        branch_taken = 1'b0;
        jr_addr      = 32'h0;
        chk("next_iaddr", iaddr, exp_addr);
        chk("next_iren", {31'd0, iREN}, 32'd1);
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; iload = 32'h0; pc_src = 2'b00;
        branch_taken = 1'b0; jr_addr = 32'h0; halt = 1'b0; stall = 1'b0;
        #2;
        // Reset values
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_iren", {31'd0, iREN}, 32'd1);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_npc", npc, 32'h4);
        chk("rst_icount", icount, 32'h0);
        chk("rst_wait", wait_cycles, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Sequential fetch: 0, 4, 8
        fetch(32'h1111_0000);
        retire(2'b00, 1'b0, 32'h0, 32'h0000_0004);
        fetch(32'h2222_0004);
        retire(2'b00, 1'b0, 32'h0, 32'h0000_0008);

        // Jump to 0x40, branch back -8 from npc 0x44 -> 0x3C
        fetch(32'h0800_0010);
        retire(2'b10, 1'b0, 32'h0, 32'h0000_0040);
        fetch(32'h1000_FFFE);
        retire(2'b01, 1'b1, 32'h0, 32'h0000_003C);
        fetch(32'h0800_0010);
        retire(2'b10, 1'b0, 32'h0, 32'h0000_0040);
        fetch(32'h1000_FFFE);
        retire(2'b01, 1'b0, 32'h0, 32'h0000_0044);

        // Register jump, region jump, wraparound
        fetch(32'h0000_0008);
        retire(2'b11, 1'b0, 32'h1000_0013, 32'h1000_0010);
        fetch(32'h0800_0100);
        retire(2'b10, 1'b0, 32'h0, 32'h1000_0400);
        fetch(32'h0000_0008);
        retire(2'b11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        chk("wrap_npc", npc, 32'h0);
        fetch(32'h3333_3333);
        retire(2'b00, 1'b0, 32'h0, 32'h0000_0000);
        fetch(32'h0000_0008);
        retire(2'b11, 1'b0, 32'h0000_0203, 32'h0000_0200);
        chk("icount_11", icount, PERF ? 32'd11 : 32'd0);

        // Icache miss for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("miss_iren", {31'd0, iREN}, 32'd1);
            chk("miss_iaddr", iaddr, 32'h0000_0200);
            chk("miss_valid", {31'd0, instr_valid}, 32'd0);
        end
        fetch(32'h4444_5555);
        chk("wait_cycles", wait_cycles, PERF ? 32'd5 : 32'd0);

        // Stall 3 cycles in ISSUE (ihit must be ignored), advance on the 4th
        stall = 1'b1;
        ihit  = 1'b1;
        iload = 32'h9999_9999;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", instr, 32'h4444_5555);
            chk("stall_iaddr", iaddr, 32'h0000_0200);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_iren", {31'd0, iREN}, 32'd0);
        end
        ihit  = 1'b0;
        stall = 1'b0;
        retire(2'b00, 1'b0, 32'h0, 32'h0000_0204);

        // Halt held off by stall, then taken with pc frozen
        fetch(32'h6666_6666);
        stall = 1'b1;
        halt  = 1'b1;
        pc_src = 2'b10;
        tick();
        tick();
        chk("stallhalt_halted", {31'd0, halted}, 32'd0);
        chk("stallhalt_valid", {31'd0, instr_valid}, 32'd1);
        stall = 1'b0;
        tick();
        halt  = 1'b0;
        pc_src = 2'b00;
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_iren", {31'd0, iREN}, 32'd0);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_iaddr", iaddr, 32'h0000_0204);
        ihit = 1'b1;
        tick();
        tick();
        ihit = 1'b0;
        chk("halt_stays", {31'd0, halted}, 32'd1);
        chk("halt_pc_frozen", iaddr, 32'h0000_0204);
        chk("icount_13", icount, PERF ? 32'd13 : 32'd0);

        // Reset out of HALTED, then asynchronous reset mid-request
        #2 nRST = 1'b0;
        #1;
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_iaddr", iaddr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        fetch(32'h7777_0000);
        retire(2'b00, 1'b0, 32'h0, 32'h0000_0004);
        ihit  = 1'b1;
        iload = 32'hABCD_0123;
        #2 nRST = 1'b0;
        #1;
        chk("async_iaddr", iaddr, 32'h0);
        chk("async_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_icount", icount, 32'h0);
        chk("async_instr", instr, 32'h7777_0000 & 32'h0);
        tick();
        chk("held_instr", instr, 32'h0);
        chk("held_iaddr", iaddr, 32'h0);
        ihit = 1'b0;
        nRST = 1'b1;
        tick();
        chk("resume_valid", {31'd0, instr_valid}, 32'd0);
        fetch(32'h8888_0000);
        retire(2'b00, 1'b0, 32'h0, 32'h0000_0004);
        chk("resume_icount", icount, PERF ? 32'd1 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch block for the single-issue MIPS core. It owns the program counter and drives the instruction cache read port (`iREN`/`iaddr`, waits on `ihit`). It holds the fetched word stable as `instr` for the control unit, then applies the control unit's `pc_src`/`halt` decision to select the next PC. It sits between the icache port and the control unit's `instr` input.

## Interface
Parameters:
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `CLK`  in  1  core clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous active-low reset.
- `ihit`  in  1  icache hit; `iload` is valid this cycle.
- `iload`  in  32  instruction word from the icache.
- `iREN`  out  1  icache read request.
- `iaddr`  out  32  icache read address, equal to `pc`.
- `instr`  out  32  latched instruction to the control unit.
- `instr_valid`  out  1  `instr` holds a fetched, unretired word.
- `npc`  out  32  `pc + 4`, i.e. the link value.
- `pc_src`  in  2  next-PC select from the control unit: 00 seq, 01 branch, 10 jump, 11 register.
- `branch_taken`  in  1  branch condition resolved true; qualifies `pc_src=01`.
- `jr_addr`  in  32  register target used for `pc_src=11`.
- `halt`  in  1  control unit decoded a halt.
- `stall`  in  1  hold the current instruction and do not advance.
- `halted`  out  1  core has halted.
- `icount`  out  32  retired-instruction count (see Configuration).
- `wait_cycles`  out  32  cycles spent in FETCH with `ihit=0` (see Configuration).

## Operation
- State machine with three states: FETCH, ISSUE, HALTED.
- FETCH:
  - `iREN=1`, `instr_valid=0`.
  - On `ihit`: `instr<=iload`, then go to ISSUE.
- ISSUE:
  - `iREN=0`, `instr_valid=1`; `instr` is held.
  - `ihit` is ignored.
  - If `stall=1`: remain in ISSUE with no change.
  - Else, if `halt=1`: go to HALTED; `pc` is not updated.
  - Else: `pc<=next_pc`, then go to FETCH.
- next_pc:
  - 00 → `npc`.
  - 01 → `npc + (sext(instr[15:0])<<2)` if `branch_taken`, else `npc`.
  - 10 → `{npc[31:28], instr[25:0], 2'b00}`.
  - 11 → `{jr_addr[31:2], 2'b00}`.
- HALTED:
  - `iREN=0`, `instr_valid=0`, `halted=1`.
  - The only exit is reset.
- Arithmetic is 32-bit modulo 2^32; `pc=32'hFFFF_FFFC` advances to 0 with no flag.
- `halt` takes priority over `pc_src`. `stall` takes priority over both.

## Timing
- Reset values:
  - state FETCH, `pc=PC_INIT`, `instr=0`.
  - `instr_valid=0`, `halted=0`, `iREN=1` (combinational from FETCH), `iaddr=PC_INIT`.
  - `icount=0`, `wait_cycles=0`.
- Latency:
  - `instr` valid on the cycle after `ihit`.
  - Minimum two cycles per instruction: FETCH hit, then ISSUE.
- `iaddr` changes only on the edge that leaves ISSUE. It is stable for the entire request, so the icache may take any number of cycles.
- `pc_src`, `branch_taken`, `jr_addr`, `halt` and `stall` are sampled only at the ISSUE edge. Values in other states are don't-care.
- `nRST` asserted in any state, including mid-request with `iREN=1`, immediately forces the reset values. A pending icache response is dropped.
- `npc` is combinational from `pc`.

## Configuration
- `FETCH_PERFCNT_EN`:
  - Defined:
    - `icount` increments on each ISSUE→FETCH or ISSUE→HALTED transition.
    - `wait_cycles` increments on each FETCH cycle with `ihit=0`.
    - Both are 32-bit and wrap.
  - Undefined: both outputs are tied to 0 and no counter flops are generated.

## Test plan
- Reset with `PC_INIT=0`, `ihit=1` every FETCH cycle, `pc_src=00` → `iaddr` sequence 0, 4, 8, one new address every 2 cycles; `instr` equals `iload` captured at each hit.
- At `pc=0x40`, `instr[15:0]=16'hFFFE`, `pc_src=01`, `branch_taken=1` → next `iaddr=0x3C`. Same with `branch_taken=0` → `0x44`.
- At `pc=0x1000_0010`, `pc_src=10`, `instr[25:0]=26'h0000100` → `iaddr=0x1000_0400`. With `pc_src=11` and `jr_addr=0x0000_0203` → `iaddr=0x200`.
- Hold `ihit=0` for 5 cycles, then hit → `iREN=1` and `iaddr` stable throughout; `instr_valid` rises 1 cycle after the hit; `wait_cycles=5` if `FETCH_PERFCNT_EN` is defined, 0 otherwise.
- `stall=1` for 3 ISSUE cycles, then 0 → `instr` and `pc` unchanged for 3 cycles, advance on the 4th. `halt=1` together with `stall=1` → no halt until `stall` drops; then `halted=1`, `iREN=0`, `pc` frozen.
- Drop `nRST` while in FETCH with `iREN=1` → asynchronous return to `pc=PC_INIT`, `instr_valid=0`, `icount=0`; normal fetch resumes after release.
